iob_fifo2stream: RTL and testbench

- Read-side adapter placed directly downstream of iob_sync_fifo.
- Converts the FIFO's read_en/data_out interface, where data_out is valid one cycle after read_en, into a valid/ready stream with full 1 word/cycle throughput.
- Holds a 2-entry output buffer that absorbs the read latency, so back-pressure from the consumer never loses or duplicates a word.

---
 rtl/iob_fifo2stream.sv | 95 +++++++++
 tb/tb_iob_fifo2stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo2stream.sv
// Read-side adapter: turns a 1-cycle-latency FIFO read port into a valid/ready stream.
// Define FIFO2STREAM_LAST_EN for packet m_last generation; SIMULATION enables the overflow check.
module iob_fifo2stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int LAST_PERIOD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO2STREAM_LAST_EN
  ,
  output logic                  m_last
`endif
);

  if (LAST_PERIOD < 1) begin : g_bad_period
    $error("LAST_PERIOD must be >= 1");
  end

  logic [1:0]            count_q, count_d, cnt_after_pop;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic                  pop;
  logic [2:0]            level;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = head_q;
  assign pop     = m_valid && m_ready;

  // Words held or already requested, after this cycle's pop; a read may only
  // be issued if its data is guaranteed a free slot when it lands.
  assign level        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_read_en = !rst && !fifo_empty && (level < 3'd2);
  assign inflight_d   = fifo_read_en;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    cnt_after_pop = count_q - {1'b0, pop};
    if (pop && count_q == 2'd2) head_d = tail_q;
    if (inflight_q) begin
      if (cnt_after_pop == 2'd0) head_d = fifo_data;
      else                       tail_d = fifo_data;
    end
    count_d = cnt_after_pop + {1'b0, inflight_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inflight_q && cnt_after_pop == 2'd2))
        else $error("iob_fifo2stream: output buffer overflow");
    end
  end
`endif

`ifdef FIFO2STREAM_LAST_EN
  localparam int PW = $clog2(LAST_PERIOD) + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(LAST_PERIOD - 1);

  logic [PW-1:0] pkt_q, pkt_d;

  assign m_last = m_valid && (pkt_q == LAST_IDX);

  always_comb begin
    pkt_d = pkt_q;
    if (pop) pkt_d = (pkt_q == LAST_IDX) ? '0 : pkt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_q <= '0;
    else     pkt_q <= pkt_d;
  end
`endif

endmodule

// File: tb/tb_iob_fifo2stream.sv
// Directed bench for iob_fifo2stream with a behavioural 1-cycle-latency FIFO model.
module tb_iob_fifo2stream;
  localparam int DW = 8;
  localparam int LP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_read_en;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO2STREAM_LAST_EN
  logic          m_last;
`endif

  always #5 clk = ~clk;

  iob_fifo2stream #(.DATA_WIDTH(DW), .LAST_PERIOD(LP)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_read_en (fifo_read_en),
    .fifo_data    (fifo_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data)
`ifdef FIFO2STREAM_LAST_EN
    ,
    .m_last       (m_last)
`endif
  );

  // FIFO model: data_out registered one cycle after read_en
  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int occ;
  assign occ        = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_read_en) begin
      fifo_data <= mem[rd_ptr[9:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr[9:0]] = v;
    wr_ptr++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor: records accepted words and checks hold-under-stall
  logic [DW-1:0] got[$];
  int            got_cyc[$];
`ifdef FIFO2STREAM_LAST_EN
  logic          got_last[$];
`endif
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'b0, m_valid}, 32'd1);
        chk("hold_data", {24'b0, m_data}, {24'b0, prev_data});
      end
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
`ifdef FIFO2STREAM_LAST_EN
        got_last.push_back(m_last);
`endif
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic wait_pops(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({name, "_timeout"}, {31'b0, got.size() >= n}, 32'd1);
  endtask

  typedef struct {
    logic          ready;
    logic          exp_re;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    int            exp_occ;
  } vec_t;

  vec_t bp[27];

  initial begin
    // Back-pressure then release, 16 words 32..47 loaded in cycle 0
    bp[0] = '{1'b0, 1'b1, 1'b0, 8'd0, 16};
    bp[1] = '{1'b0, 1'b1, 1'b0, 8'd0, 15};
    for (int i = 2; i < 10; i++) bp[i] = '{1'b0, 1'b0, 1'b1, 8'd32, 14};
    for (int i = 10; i < 24; i++) bp[i] = '{1'b1, 1'b1, 1'b1, 8'(32 + i - 10), 14 - (i - 10)};
    bp[24] = '{1'b1, 1'b0, 1'b1, 8'd46, 0};
    bp[25] = '{1'b1, 1'b0, 1'b1, 8'd47, 0};
    bp[26] = '{1'b1, 1'b0, 1'b0, 8'd0, 0};

    rst     = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_data", {24'b0, m_data}, 32'd0);
    chk("rst_read_en", {31'b0, fifo_read_en}, 32'd0);
`ifdef FIFO2STREAM_LAST_EN
    chk("rst_last", {31'b0, m_last}, 32'd0);
`endif
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", {31'b0, m_valid}, 32'd0);
    chk("idle_read_en", {31'b0, fifo_read_en}, 32'd0);

    // Table-driven back-pressure sequence
    step();
    for (int v = 32; v < 48; v++) push(8'(v));
    for (int i = 0; i < 27; i++) begin
      if (i > 0) step();
      m_ready = bp[i].ready;
      @(negedge clk);
      chk($sformatf("bp%0d_read_en", i), {31'b0, fifo_read_en}, {31'b0, bp[i].exp_re});
      chk($sformatf("bp%0d_valid", i), {31'b0, m_valid}, {31'b0, bp[i].exp_valid});
      if (bp[i].exp_valid) chk($sformatf("bp%0d_data", i), {24'b0, m_data}, {24'b0, bp[i].exp_data});
      chk($sformatf("bp%0d_occ", i), occ, bp[i].exp_occ);
    end

    // Burst with m_ready held high: latency 2, one word per cycle
    begin
      int l;
      got.delete(); got_cyc.delete();
      step();
      l = cyc;
      for (int v = 32; v < 48; v++) push(8'(v));
      wait_pops(16, 100, "burst");
      chk("burst_count", got.size(), 32'd16);
      for (int k = 0; k < got.size(); k++) begin
        chk($sformatf("burst_data%0d", k), {24'b0, got[k]}, 32'(32 + k));
        chk($sformatf("burst_cyc%0d", k), got_cyc[k], l + 2 + k);
      end
      @(negedge clk);
      chk("burst_end_valid", {31'b0, m_valid}, 32'd0);
      chk("burst_end_empty", {31'b0, fifo_empty}, 32'd1);
    end

    // Random stall over 64 words
    begin
      int n = 0;
      got.delete(); got_cyc.delete();
      step();
      for (int v = 0; v < 64; v++) push(8'(v));
      while (got.size() < 64 && n < 2000) begin
        m_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      chk("rand_count", got.size(), 32'd64);
      for (int k = 0; k < got.size(); k++)
        chk($sformatf("rand_data%0d", k), {24'b0, got[k]}, 32'(k));
      m_ready = 1'b1;
      repeat (4) step();
    end

    // Underflow: single word, then idle
    got.delete(); got_cyc.delete();
    step();
    push(8'hA5);
    wait_pops(1, 20, "under");
    if (got.size() > 0) chk("under_data", {24'b0, got[0]}, 32'hA5);
    repeat (5) begin
      @(negedge clk);
      chk("under_read_en", {31'b0, fifo_read_en}, 32'd0);
      chk("under_valid", {31'b0, m_valid}, 32'd0);
    end
    chk("under_count", got.size(), 32'd1);

    // Asynchronous reset while the buffer is full
    m_ready = 1'b0;
    got.delete(); got_cyc.delete();
    step();
    for (int v = 100; v < 108; v++) push(8'(v));
    repeat (5) step();
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, m_valid}, 32'd1);
    chk("pre_rst_data", {24'b0, m_data}, 32'd100);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, m_valid}, 32'd0);
    chk("mid_rst_data", {24'b0, m_data}, 32'd0);
    chk("mid_rst_read_en", {31'b0, fifo_read_en}, 32'd0);
    chk("mid_rst_occ", occ, 6);
    step();
    rst     = 1'b0;
    m_ready = 1'b1;
    got.delete(); got_cyc.delete();
    wait_pops(6, 40, "post_rst");
    for (int k = 0; k < got.size(); k++)
      chk($sformatf("post_rst_data%0d", k), {24'b0, got[k]}, 32'(102 + k));

`ifdef FIFO2STREAM_LAST_EN
    // Packet boundaries with LAST_PERIOD=4
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    got.delete(); got_cyc.delete(); got_last.delete();
    for (int v = 32; v < 48; v++) push(8'(v));
    wait_pops(16, 100, "last");
    for (int k = 0; k < got.size(); k++) begin
      chk($sformatf("last_data%0d", k), {24'b0, got[k]}, 32'(32 + k));
      chk($sformatf("last_flag%0d", k), {31'b0, got_last[k]}, {31'b0, (k % 4) == 3});
    end
    @(negedge clk);
    chk("last_idle", {31'b0, m_last}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
